// File: rtl/tinynpu_host_seq.sv
// Host-side sequencer for the TinyNPU controller: streams activation and weight
// words into the load interface, fires one MAC, then drains the result lanes to the host.
module tinynpu_host_seq #(
  parameter int SIZE   = 4,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_val,
  output logic                      in_rdy,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      x_load_val,
  output logic                      w_load_val,
  output logic [$clog2(SIZE)-1:0]   w_load_sel,
  output logic [DATA_W-1:0]         load_data,
  output logic                      mac_val,
  input  logic                      res_val,
  input  logic [SIZE*ACC_W-1:0]     res_data,
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic [ACC_W-1:0]          out_data,
  output logic [3:0]                trace_state
);

  localparam int WCNT_W = $clog2(DEPTH);
  localparam int SEL_W  = $clog2(SIZE);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(DEPTH - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(SIZE - 1);

  typedef enum logic [3:0] {
    LDX = 4'b0001,
    LDW = 4'b0010,
    MAC = 4'b0100,
    DRN = 4'b1000
  } state_t;

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [SEL_W-1:0]    col_q, col_d;
  logic [SEL_W-1:0]    lane_q, lane_d;
  logic                have_res_q, have_res_d;
  logic [ACC_W-1:0]    res_q [SIZE];
  logic [ACC_W-1:0]    res_d [SIZE];

  // NOTE: the result register is only a few words, so it is reset along with the
  // control state; that keeps out_data at zero during and straight after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LDX;
      wcnt_q     <= '0;
      col_q      <= '0;
      lane_q     <= '0;
      have_res_q <= 1'b0;
      for (int i = 0; i < SIZE; i++) res_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational block.
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      col_q      <= col_d;
      lane_q     <= lane_d;
      have_res_q <= have_res_d;
      for (int i = 0; i < SIZE; i++) res_q[i] <= res_d[i];
    end
  end

  always_comb begin
    // NOTE: every output and next-state term gets a default first so no path
    // through the case statement can leave a latch behind.
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    col_d      = col_q;
    lane_d     = lane_q;
    have_res_d = have_res_q;
    for (int i = 0; i < SIZE; i++) res_d[i] = res_q[i];
    in_rdy     = 1'b0;
    x_load_val = 1'b0;
    w_load_val = 1'b0;
    mac_val    = 1'b0;
    out_val    = 1'b0;
    out_data   = '0;

    unique case (state_q)
      LDX: begin
        // Gated by rst so nothing is accepted while reset is held.
        in_rdy = rst;
        if (in_val && rst) begin
          x_load_val = 1'b1;
          if (wcnt_q == WCNT_LAST) begin
            wcnt_d  = '0;
            state_d = LDW;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
      LDW: begin
        in_rdy = rst;
        if (in_val && rst) begin
          w_load_val = 1'b1;
          if (wcnt_q == WCNT_LAST) begin
            wcnt_d = '0;
            if (col_q == SEL_LAST) begin
              col_d   = '0;
              state_d = MAC;
            end else begin
              col_d = col_q + SEL_W'(1);
            end
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
      MAC: begin
        mac_val = 1'b1;
        state_d = DRN;
      end
      DRN: begin
        if (!have_res_q) begin
          if (res_val) begin
            for (int i = 0; i < SIZE; i++) res_d[i] = res_data[i*ACC_W +: ACC_W];
            have_res_d = 1'b1;
            lane_d     = '0;
          end
        end else begin
          // Stray res_val is ignored here; the captured vector stays put until drained.
          out_val  = 1'b1;
          out_data = res_q[lane_q];
          if (out_rdy) begin
            if (lane_q == SEL_LAST) begin
              lane_d     = '0;
              have_res_d = 1'b0;
              state_d    = LDX;
            end else begin
              lane_d = lane_q + SEL_W'(1);
            end
          end
        end
      end
      default: state_d = LDX;
    endcase
  end

  assign w_load_sel  = col_q;
  assign load_data   = in_data;
  assign trace_state = state_q;

endmodule

// File: tb/tb_tinynpu_host_seq.sv
// Randomized bench for tinynpu_host_seq: a transaction-level model predicts every
// output each cycle, and directed runs pin the model to hand-computed sequences.
module tb_tinynpu_host_seq;

  localparam int SIZE   = 4;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int NWORDS = DEPTH + SIZE * DEPTH;
  localparam int LIM    = 2000;

  localparam int P_LOAD = 0;
  localparam int P_MAC  = 1;
  localparam int P_WAIT = 2;
  localparam int P_DRN  = 3;

  localparam int SEL_EXP [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_val;
  logic                  in_rdy;
  logic [DATA_W-1:0]     in_data;
  logic                  x_load_val;
  logic                  w_load_val;
  logic [1:0]            w_load_sel;
  logic [DATA_W-1:0]     load_data;
  logic                  mac_val;
  logic                  res_val;
  logic [SIZE*ACC_W-1:0] res_data;
  logic                  out_val;
  logic                  out_rdy;
  logic [ACC_W-1:0]      out_data;
  logic [3:0]            trace_state;

  tinynpu_host_seq #(.SIZE(SIZE), .DEPTH(DEPTH), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
    .x_load_val(x_load_val), .w_load_val(w_load_val), .w_load_sel(w_load_sel),
    .load_data(load_data), .mac_val(mac_val),
    .res_val(res_val), .res_data(res_data),
    .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
    .trace_state(trace_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: words accepted so far, then mac, wait, drain index.
  int          m_phase = P_LOAD;
  int          m_k     = 0;
  int          m_idx   = 0;
  logic [31:0] m_lane [SIZE];

  // Observed DUT activity, cleared per transaction and compared to literals.
  int          x_cnt;
  int          mac_cnt;
  int          sel_q [$];
  logic [7:0]  xd_q [$];
  logic [31:0] out_q [$];

  always @(negedge clk) begin
    logic e_rdy, e_x, e_w, e_mac, e_ov;
    logic [3:0] e_tr;
    if (!rst) begin
      check("rst_in_rdy", in_rdy, 0);
      check("rst_x_load", x_load_val, 0);
      check("rst_w_load", w_load_val, 0);
      check("rst_mac", mac_val, 0);
      check("rst_out_val", out_val, 0);
      check("rst_out_data", out_data, 0);
      check("rst_trace", trace_state, 4'b0001);
      m_phase = P_LOAD;
      m_k     = 0;
      m_idx   = 0;
    end else begin
      e_rdy = (m_phase == P_LOAD);
      e_x   = e_rdy && in_val && (m_k < DEPTH);
      e_w   = e_rdy && in_val && (m_k >= DEPTH);
      e_mac = (m_phase == P_MAC);
      e_ov  = (m_phase == P_DRN);
      if (m_phase == P_LOAD) e_tr = (m_k < DEPTH) ? 4'b0001 : 4'b0010;
      else if (m_phase == P_MAC) e_tr = 4'b0100;
      else e_tr = 4'b1000;

      check("in_rdy", in_rdy, e_rdy);
      check("x_load_val", x_load_val, e_x);
      check("w_load_val", w_load_val, e_w);
      check("mac_val", mac_val, e_mac);
      check("out_val", out_val, e_ov);
      check("trace_state", trace_state, e_tr);
      check("load_data", load_data, in_data);
      if (e_w) check("w_load_sel", w_load_sel, (m_k - DEPTH) / DEPTH);
      if (e_ov) check("out_data", out_data, m_lane[m_idx]);

      if (x_load_val) begin x_cnt++; xd_q.push_back(load_data); end
      if (w_load_val) sel_q.push_back(int'(w_load_sel));
      if (mac_val) mac_cnt++;
      if (out_val && out_rdy) out_q.push_back(out_data);

      case (m_phase)
        P_LOAD: if (in_val) begin
          m_k++;
          if (m_k == NWORDS) m_phase = P_MAC;
        end
        P_MAC: m_phase = P_WAIT;
        P_WAIT: if (res_val) begin
          for (int i = 0; i < SIZE; i++) m_lane[i] = res_data[i*ACC_W +: ACC_W];
          m_idx   = 0;
          m_phase = P_DRN;
        end
        default: if (out_rdy) begin
          m_idx++;
          if (m_idx == SIZE) begin
            m_idx   = 0;
            m_k     = 0;
            m_phase = P_LOAD;
          end
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_res();
    for (int i = 0; i < SIZE; i++) res_data[i*ACC_W +: ACC_W] = $urandom;
  endtask

  task automatic run_tx(input logic [31:0] ln [SIZE], input bit seq_data, input bit gaps,
                        input bit stray, input int rdy_mode, input int abort_at,
                        output bit aborted);
    int guard;
    int c;
    aborted = 1'b0;
    x_cnt = 0; mac_cnt = 0;
    sel_q.delete(); xd_q.delete(); out_q.delete();

    guard = 0;
    while (m_phase == P_LOAD && guard < LIM) begin
      in_val  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = seq_data ? DATA_W'(m_k + 1) : DATA_W'($urandom);
      res_val = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      junk_res();
      step();
      guard++;
    end
    check("load_timeout", guard < LIM, 1);
    in_val = 1'b0;
    res_val = 1'b0;

    guard = 0;
    while (m_phase != P_WAIT && guard < 20) begin step(); guard++; end
    check("mac_timeout", m_phase == P_WAIT, 1);
    if (gaps) repeat ($urandom_range(0, 3)) step();
    res_val = 1'b1;
    for (int i = 0; i < SIZE; i++) res_data[i*ACC_W +: ACC_W] = ln[i];
    step();
    res_val = 1'b0;
    junk_res();

    guard = 0;
    c = 0;
    while (m_phase == P_DRN && guard < LIM) begin
      if (abort_at >= 0 && m_idx == abort_at) begin
        rst = 1'b0;
        #1;
        check("abort_out_val", out_val, 0);
        check("abort_trace", trace_state, 4'b0001);
        repeat (2) step();
        rst = 1'b1;
        out_rdy = 1'b0;
        aborted = 1'b1;
        return;
      end
      case (rdy_mode)
        0: out_rdy = 1'b1;
        1: out_rdy = (c < 5) ? 1'b0 : 1'(c % 2);
        default: out_rdy = 1'($urandom_range(0, 1));
      endcase
      if (rdy_mode == 1 && c > 0 && c < 5) check("stall_hold", out_data, ln[0]);
      res_val = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      junk_res();
      step();
      c++;
      guard++;
    end
    check("drain_timeout", guard < LIM, 1);
    out_rdy = 1'b0;
    res_val = 1'b0;
    step();
  endtask

  task automatic check_logs(input logic [31:0] ln [SIZE], input bit seq_data);
    check("x_count", x_cnt, 4);
    check("w_count", sel_q.size(), 16);
    for (int j = 0; j < 16 && j < sel_q.size(); j++) check("sel_seq", sel_q[j], SEL_EXP[j]);
    check("mac_pulses", mac_cnt, 1);
    check("out_count", out_q.size(), SIZE);
    for (int j = 0; j < SIZE && j < out_q.size(); j++) check("out_seq", out_q[j], ln[j]);
    if (seq_data)
      for (int j = 0; j < DEPTH && j < xd_q.size(); j++) check("x_words", xd_q[j], j + 1);
  endtask

  initial begin
    logic [31:0] ln [SIZE];
    bit ab;
    rst = 1'b0; in_val = 1'b0; in_data = '0; res_val = 1'b0; res_data = '0; out_rdy = 1'b0;
    repeat (3) step();
    rst = 1'b1;

    ln = '{32'd10, 32'd20, 32'd30, 32'd40};
    run_tx(ln, 1, 0, 0, 0, -1, ab);
    check_logs(ln, 1);

    run_tx(ln, 1, 0, 0, 1, -1, ab);
    check_logs(ln, 1);

    for (int i = 0; i < SIZE; i++) ln[i] = $urandom;
    run_tx(ln, 1, 1, 1, 2, -1, ab);
    check_logs(ln, 1);

    ln = '{32'd10, 32'd20, 32'd30, 32'd40};
    run_tx(ln, 1, 0, 0, 0, 2, ab);
    check("abort_taken", ab, 1);
    check("abort_lanes_seen", out_q.size(), 2);

    ln = '{32'd5, 32'd6, 32'd7, 32'd8};
    run_tx(ln, 1, 0, 0, 0, -1, ab);
    check_logs(ln, 1);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < SIZE; i++) ln[i] = $urandom;
      run_tx(ln, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)), -1, ab);
      check_logs(ln, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
